cpu_state_injector: RTL and testbench

Synthesizable successor to the simulation-only register forcing used at bring-up. After reset or on request, it drives the CPU's `*_new`/`*_ld` register-load pins with preset values, in two timed phases. It is generalised to `NUM_REGS` register channels with per-channel masking and a phase-B increment. It sits between the top level and the CPU core, clocked by the system `Clk` and paced by the CPU clock-enable. An optional trace FIFO records CPU PC values after injection completes.

---
 rtl/cpu_state_injector_if.sv | 58 +++++
 rtl/cpu_state_injector.sv | 277 +++++++++++++++++++++++++++
 tb/tb_cpu_state_injector.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_state_injector_if.sv
// ---------------------------------------------------------------------------
// cpu_state_injector_if
//
// Bundles the control, register-load and trace signals of cpu_state_injector.
// Clock and reset stay plain ports on the module.
//
// Handshake: `arm` is a level request sampled on every Clk. It is accepted on
// any Clk edge where the injector is not busy (ready == !busy). A request seen
// while busy is dropped, not queued.
//
// Signals (direction seen from the injector, modport slave):
//   cpu_ce      in   one-Clk pulse per CPU clock
//   arm         in   start request
//   inj_value   in   16*NUM_REGS preset values, latched on accept
//   inj_mask    in   per-channel load enables, latched on accept
//   inc_mask    in   per-channel +1 in phase B, latched on accept
//   reg_new     out  load values to the CPU
//   reg_ld      out  load strobes to the CPU
//   busy        out  high in DELAY / PHASE_A / PHASE_B
//   done        out  high in DONE
//   trace_pc    in   CPU PC sampled into the trace FIFO
//   trace_rd    in   trace FIFO pop
//   trace_data  out  trace FIFO head (first-word fall-through)
//   trace_empty out  trace FIFO empty
//   trace_ovf   out  sticky trace overflow
//   dbg_state   out  current FSM state, for checkers and debug
// ---------------------------------------------------------------------------
interface cpu_state_injector_if #(
    parameter int NUM_REGS = 2
);
    logic                    cpu_ce;
    logic                    arm;
    logic [16*NUM_REGS-1:0]  inj_value;
    logic [NUM_REGS-1:0]     inj_mask;
    logic [NUM_REGS-1:0]     inc_mask;
    logic [16*NUM_REGS-1:0]  reg_new;
    logic [NUM_REGS-1:0]     reg_ld;
    logic                    busy;
    logic                    done;
    logic [15:0]             trace_pc;
    logic                    trace_rd;
    logic [15:0]             trace_data;
    logic                    trace_empty;
    logic                    trace_ovf;
    logic [2:0]              dbg_state;

    modport master (
        output cpu_ce, arm, inj_value, inj_mask, inc_mask, trace_pc, trace_rd,
        input  reg_new, reg_ld, busy, done, trace_data, trace_empty, trace_ovf,
               dbg_state
    );

    modport slave (
        input  cpu_ce, arm, inj_value, inj_mask, inc_mask, trace_pc, trace_rd,
        output reg_new, reg_ld, busy, done, trace_data, trace_empty, trace_ovf,
               dbg_state
    );
endinterface

// File: rtl/cpu_state_injector.sv
// ---------------------------------------------------------------------------
// cpu_state_injector
//
// Drives the CPU's register-load pins (reg_new / reg_ld) with preset values
// after reset or on request, in two timed phases paced by cpu_ce:
//   DELAY   : START_DELAY cpu_ce ticks, no strobes
//   PHASE_A : HOLD_A ticks, reg_ld = inj_mask, reg_new = latched values
//   PHASE_B : HOLD_B ticks, as A but inc_mask channels drive value+1
//   DONE    : strobes off, done high until the next arm
// All outputs are registered; they are computed from the next state so a
// strobe lines up exactly with the phase it belongs to.
//
// Ports:
//   Clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      cpu_state_injector_if.slave (see interface file for signals)
//
// Build option:
//   CPU_INJ_TRACE_EN  when defined, builds a TRACE_DEPTH x 16 trace FIFO that
//                     records trace_pc on every cpu_ce while in DONE. When
//                     undefined, trace outputs are tied to their idle values.
// ---------------------------------------------------------------------------
module cpu_state_injector #(
    parameter int NUM_REGS    = 2,
    parameter int START_DELAY = 2,
    parameter int HOLD_A      = 4,
    parameter int HOLD_B      = 2,
    parameter bit AUTO_ARM    = 1'b1,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                   Clk,
    input  logic                   reset_n,
    cpu_state_injector_if.slave    bus
);
    localparam int W     = 16 * NUM_REGS;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] START_CNT  = CNT_W'(START_DELAY);
    localparam logic [CNT_W-1:0] HOLD_A_CNT = CNT_W'(HOLD_A);
    localparam logic [CNT_W-1:0] HOLD_B_CNT = CNT_W'(HOLD_B);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DELAY   = 3'd1,
        ST_PHASE_A = 3'd2,
        ST_PHASE_B = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]        val_q, val_d;
    logic [NUM_REGS-1:0] mask_q, mask_d;
    logic [NUM_REGS-1:0] inc_q, inc_d;
    logic                auto_q, auto_d;
    logic                arm_take;

    logic [NUM_REGS-1:0] reg_ld_q, reg_ld_d;
    logic [W-1:0]        reg_new_q, reg_new_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        val_d    = val_q;
        mask_d   = mask_q;
        inc_d    = inc_q;
        auto_d   = 1'b0;     // pending auto-arm lasts exactly one Clk
        arm_take = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // auto_q stands in for arm on the first Clk after reset
                if (bus.arm || auto_q) begin
                    arm_take = 1'b1;
                    val_d    = bus.inj_value;
                    mask_d   = bus.inj_mask;
                    inc_d    = bus.inc_mask;
                    if (START_DELAY == 0) begin
                        state_d = ST_PHASE_A;
                        cnt_d   = HOLD_A_CNT;
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = START_CNT;
                    end
                end
            end

            ST_DELAY: begin
                if (bus.cpu_ce) begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_PHASE_A;
                        cnt_d   = HOLD_A_CNT;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            ST_PHASE_A: begin
                if (bus.cpu_ce) begin
                    if (cnt_q == CNT_ONE) begin
                        if (HOLD_B == 0) begin
                            state_d = ST_DONE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_PHASE_B;
                            cnt_d   = HOLD_B_CNT;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            ST_PHASE_B: begin
                if (bus.cpu_ce) begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registered outputs, derived from the next state
    // -----------------------------------------------------------------------
    always_comb begin
        reg_ld_d  = '0;
        reg_new_d = '0;
        if ((state_d == ST_PHASE_A) || (state_d == ST_PHASE_B)) begin
            reg_ld_d = mask_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((state_d == ST_PHASE_B) && inc_d[i]) begin
                    reg_new_d[16*i +: 16] = val_d[16*i +: 16] + 16'd1;
                end else begin
                    reg_new_d[16*i +: 16] = val_d[16*i +: 16];
                end
            end
        end
        busy_d = (state_d == ST_DELAY) || (state_d == ST_PHASE_A) ||
                 (state_d == ST_PHASE_B);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            val_q     <= '0;
            mask_q    <= '0;
            inc_q     <= '0;
            auto_q    <= AUTO_ARM;
            reg_ld_q  <= '0;
            reg_new_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            val_q     <= val_d;
            mask_q    <= mask_d;
            inc_q     <= inc_d;
            auto_q    <= auto_d;
            reg_ld_q  <= reg_ld_d;
            reg_new_q <= reg_new_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.reg_ld    = reg_ld_q;
    assign bus.reg_new   = reg_new_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

`ifdef CPU_INJ_TRACE_EN
    // -----------------------------------------------------------------------
    // Trace FIFO: captures trace_pc on each cpu_ce while in DONE.
    // -----------------------------------------------------------------------
    localparam int AW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(TRACE_DEPTH);

    logic [15:0]   mem_q [TRACE_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          empty_q, empty_d;
    logic [15:0]   head_q, head_d;
    logic          want_wr, do_wr, do_rd, mem_we;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        want_wr = (state_q == ST_DONE) && bus.cpu_ce;
        do_rd   = bus.trace_rd && (count_q != '0);
        // A full FIFO still accepts a write when the same Clk pops.
        do_wr   = want_wr && ((count_q != DEPTH_CNT) || do_rd);

        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_wr && !do_rd) count_d = count_q + (AW + 1)'(1);
        if (do_rd && !do_wr) count_d = count_q - (AW + 1)'(1);
        if (want_wr && !do_wr) ovf_d = 1'b1;

        // Arm restarts tracing from an empty FIFO; it overrides any write.
        mem_we = do_wr && !arm_take;
        if (arm_take) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end

        // Head register: bypass the word being written when it becomes head.
        empty_d = (count_d == '0);
        head_d  = '0;
        if (!empty_d) begin
            if (mem_we && (rd_ptr_d == wr_ptr_q)) head_d = bus.trace_pc;
            else                                  head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= bus.trace_pc;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    assign bus.trace_data  = head_q;
    assign bus.trace_empty = empty_q;
    assign bus.trace_ovf   = ovf_q;
`else
    // No trace FIFO: outputs idle, trace inputs intentionally ignored.
    logic unused_trace;
    assign unused_trace    = ^{bus.trace_pc, bus.trace_rd};
    assign bus.trace_data  = 16'h0000;
    assign bus.trace_empty = 1'b1;
    assign bus.trace_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_state_injector.sv
// ---------------------------------------------------------------------------
// tb_cpu_state_injector
//
// Randomised bench for cpu_state_injector. The reference model counts cpu_ce
// pulses since the last accepted arm and maps that count onto the phase
// windows (START_DELAY, HOLD_A, HOLD_B); the trace FIFO is modelled with a
// queue. Scenario tasks add directed checks on top of the per-cycle checks.
// ---------------------------------------------------------------------------
module tb_cpu_state_injector;
    localparam int NUM_REGS    = 2;
    localparam int START_DELAY = 2;
    localparam int HOLD_A      = 4;
    localparam int HOLD_B      = 2;
    localparam int AUTO_ARM    = 1;
    localparam int TRACE_DEPTH = 16;
    localparam int W           = 16 * NUM_REGS;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 Clk = ~Clk;

    cpu_state_injector_if #(.NUM_REGS(NUM_REGS)) bus ();

    cpu_state_injector #(
        .NUM_REGS(NUM_REGS), .START_DELAY(START_DELAY), .HOLD_A(HOLD_A),
        .HOLD_B(HOLD_B), .AUTO_ARM(AUTO_ARM), .TRACE_DEPTH(TRACE_DEPTH)
    ) dut (
        .Clk(Clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    bit                  m_armed;
    bit                  m_auto;
    int                  m_n;          // cpu_ce pulses since accepted arm
    logic [W-1:0]        m_val;
    logic [NUM_REGS-1:0] m_mask;
    logic [NUM_REGS-1:0] m_inc;
    logic [15:0]         m_fifo[$];
    bit                  m_ovf;
    logic [15:0]         exp_q[$];

    // directed-scenario observations
    int          cnt_a, cnt_b, ld_ce;
    bit          seen_ld0;
    logic [1:0]  want_ld;
    logic [15:0] want_pc_a, want_pc_b, want_sp;

    // 0 idle, 1 delay, 2 phase A, 3 phase B, 4 done
    function automatic int m_phase();
        if (!m_armed) return 0;
        if (m_n < START_DELAY) return 1;
        if (m_n < START_DELAY + HOLD_A) return 2;
        if (m_n < START_DELAY + HOLD_A + HOLD_B) return 3;
        return 4;
    endfunction

    task automatic model_reset();
        m_armed = 1'b0;
        m_n     = 0;
        m_auto  = (AUTO_ARM != 0);
        m_fifo.delete();
        m_ovf   = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset_n       = 1'b0;
        bus.cpu_ce    = 1'b0;
        bus.arm       = 1'b0;
        bus.trace_rd  = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
    endtask

    // Called at posedge+1; the next posedge becomes the auto-arm edge.
    task automatic release_reset();
        #1 reset_n = 1'b1;
    endtask

    task automatic set_inputs(input logic [W-1:0] v, input logic [NUM_REGS-1:0] m,
                              input logic [NUM_REGS-1:0] inc);
        bus.inj_value = v;
        bus.inj_mask  = m;
        bus.inc_mask  = inc;
    endtask

    // One Clk: drive at negedge, update model at posedge, check at posedge+1.
    task automatic step(input logic ce, input logic a, input logic rd, input logic [15:0] pc);
        int ph;
        logic [NUM_REGS-1:0] e_ld;
        logic [W-1:0] e_new;
        logic [15:0] v, e_data;
        logic e_busy, e_done, e_empty, e_ovf;
        @(negedge Clk);
        ph = m_phase();
        if (ph >= 1 && ph <= 3) begin
            // values must have been latched; scramble the live inputs
            for (int i = 0; i < NUM_REGS; i++) bus.inj_value[16*i +: 16] = 16'($urandom);
            bus.inj_mask = NUM_REGS'($urandom);
            bus.inc_mask = NUM_REGS'($urandom);
        end
        bus.cpu_ce   = ce;
        bus.arm      = a;
        bus.trace_rd = rd;
        bus.trace_pc = pc;
        @(posedge Clk);
        if (rd && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (ce && ph == 4) begin
            if (m_fifo.size() < TRACE_DEPTH) m_fifo.push_back(pc);
            else m_ovf = 1'b1;
        end
        if (ph == 0 || ph == 4) begin
            if (a || m_auto) begin
                m_armed = 1'b1;
                m_n     = 0;
                m_val   = bus.inj_value;
                m_mask  = bus.inj_mask;
                m_inc   = bus.inc_mask;
                m_fifo.delete();
                m_ovf   = 1'b0;
            end
        end else if (ce) begin
            m_n++;
        end
        m_auto = 1'b0;

        ph     = m_phase();
        e_ld   = '0;
        e_new  = '0;
        if (ph == 2 || ph == 3) begin
            e_ld = m_mask;
            for (int i = 0; i < NUM_REGS; i++) begin
                v = m_val[16*i +: 16];
                if (ph == 3 && m_inc[i]) v = v + 16'd1;
                e_new[16*i +: 16] = v;
            end
        end
        e_busy = (ph >= 1 && ph <= 3);
        e_done = (ph == 4);
`ifdef CPU_INJ_TRACE_EN
        e_empty = (m_fifo.size() == 0);
        e_data  = e_empty ? 16'h0000 : m_fifo[0];
        e_ovf   = m_ovf;
`else
        e_empty = 1'b1;
        e_data  = 16'h0000;
        e_ovf   = 1'b0;
`endif
        #1;
        n_checks++;
        if (bus.reg_ld !== e_ld) begin
            n_fail++; $display("FAIL reg_ld t=%0t got %b want %b", $time, bus.reg_ld, e_ld);
        end
        n_checks++;
        if (bus.reg_new !== e_new) begin
            n_fail++; $display("FAIL reg_new t=%0t got %h want %h", $time, bus.reg_new, e_new);
        end
        n_checks++;
        if (bus.busy !== e_busy) begin
            n_fail++; $display("FAIL busy t=%0t got %b want %b", $time, bus.busy, e_busy);
        end
        n_checks++;
        if (bus.done !== e_done) begin
            n_fail++; $display("FAIL done t=%0t got %b want %b", $time, bus.done, e_done);
        end
        n_checks++;
        if (bus.trace_empty !== e_empty) begin
            n_fail++; $display("FAIL trace_empty t=%0t got %b want %b", $time, bus.trace_empty, e_empty);
        end
        n_checks++;
        if (bus.trace_ovf !== e_ovf) begin
            n_fail++; $display("FAIL trace_ovf t=%0t got %b want %b", $time, bus.trace_ovf, e_ovf);
        end
        n_checks++;
        if (bus.trace_data !== e_data) begin
            n_fail++; $display("FAIL trace_data t=%0t got %h want %h", $time, bus.trace_data, e_data);
        end
    endtask

    // Random cpu_ce pacing until the model reaches DONE, with a cycle budget.
    task automatic run_to_done(input int arm_pct);
        logic [NUM_REGS-1:0] obs_ld;
        logic [W-1:0] obs_new;
        logic ce, a;
        int cyc;
        cnt_a = 0; cnt_b = 0; ld_ce = 0; seen_ld0 = 1'b0; cyc = 0;
        while (m_phase() != 4 && cyc < 400) begin
            obs_ld  = bus.reg_ld;
            obs_new = bus.reg_new;
            ce = ($urandom_range(0, 2) == 0);
            a  = (m_phase() >= 1 && m_phase() <= 3 && $urandom_range(0, 99) < arm_pct);
            if (ce && obs_ld != '0) ld_ce++;
            if (obs_ld[0]) seen_ld0 = 1'b1;
            if (ce && obs_ld == want_ld && obs_new[0 +: 16] == want_sp) begin
                if (obs_new[16 +: 16] == want_pc_a) cnt_a++;
                if (obs_new[16 +: 16] == want_pc_b) cnt_b++;
            end
            step(ce, a, 1'($urandom_range(0, 1)), 16'($urandom));
            cyc++;
        end
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++; $display("FAIL run_to_done timeout done=%b after %0d cycles", bus.done, cyc);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (bus.reg_ld !== '0) begin n_fail++; $display("FAIL reset_reg_ld got %b want 0", bus.reg_ld); end
        n_checks++;
        if (bus.reg_new !== '0) begin n_fail++; $display("FAIL reset_reg_new got %h want 0", bus.reg_new); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++;
        if (bus.trace_empty !== 1'b1) begin n_fail++; $display("FAIL reset_trace_empty got %b want 1", bus.trace_empty); end
        n_checks++;
        if (bus.trace_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_trace_ovf got %b want 0", bus.trace_ovf); end
        n_checks++;
        if (bus.trace_data !== 16'h0000) begin n_fail++; $display("FAIL reset_trace_data got %h want 0", bus.trace_data); end
    endtask

    task automatic test_auto_arm();
        set_inputs({16'h000C, 16'hFFFE}, 2'b11, 2'b10);
        want_ld = 2'b11; want_pc_a = 16'h000C; want_pc_b = 16'h000D; want_sp = 16'hFFFE;
        release_reset();
        run_to_done(0);
        n_checks++;
        if (cnt_a != HOLD_A) begin n_fail++; $display("FAIL auto_phase_a_ticks got %0d want %0d", cnt_a, HOLD_A); end
        n_checks++;
        if (cnt_b != HOLD_B) begin n_fail++; $display("FAIL auto_phase_b_ticks got %0d want %0d", cnt_b, HOLD_B); end
        n_checks++;
        if (ld_ce != HOLD_A + HOLD_B) begin n_fail++; $display("FAIL auto_strobe_ticks got %0d want %0d", ld_ce, HOLD_A + HOLD_B); end
        repeat (6) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 16'($urandom));
    endtask

    task automatic test_mask();
        apply_reset();
        set_inputs({16'h000C, 16'hFFFE}, 2'b10, 2'b10);
        want_ld = 2'b10; want_pc_a = 16'h000C; want_pc_b = 16'h000D; want_sp = 16'hFFFE;
        release_reset();
        run_to_done(0);
        n_checks++;
        if (seen_ld0 !== 1'b0) begin n_fail++; $display("FAIL mask_ld0 got %b want 0", seen_ld0); end
        n_checks++;
        if (cnt_a != HOLD_A || cnt_b != HOLD_B) begin
            n_fail++; $display("FAIL mask_pc_ticks got %0d/%0d want %0d/%0d", cnt_a, cnt_b, HOLD_A, HOLD_B);
        end
    endtask

    task automatic test_wrap();
        set_inputs({16'hFFFF, 16'h1234}, 2'b11, 2'b10);
        want_ld = 2'b11; want_pc_a = 16'hFFFF; want_pc_b = 16'h0000; want_sp = 16'h1234;
        step(1'b0, 1'b1, 1'b0, 16'h0);   // arm from DONE
        run_to_done(0);
        n_checks++;
        if (cnt_b != HOLD_B) begin n_fail++; $display("FAIL wrap_phase_b got %0d ticks of 0000 want %0d", cnt_b, HOLD_B); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        set_inputs({16'h0200, 16'h0300}, 2'b11, 2'b01);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        cyc = 0;
        while (m_phase() != 2 && cyc < 100) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 16'h0);
            cyc++;
        end
        n_checks++;
        if (bus.reg_ld !== 2'b11) begin n_fail++; $display("FAIL mid_pre_reset_ld got %b want 11", bus.reg_ld); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.reg_ld !== '0) begin n_fail++; $display("FAIL mid_reset_ld got %b want 00", bus.reg_ld); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got %b want 0", bus.busy); end
        apply_reset();
        set_inputs({16'h000C, 16'hFFFE}, 2'b11, 2'b10);
        want_ld = 2'b11; want_pc_a = 16'h000C; want_pc_b = 16'h000D; want_sp = 16'hFFFE;
        release_reset();
        run_to_done(0);
        n_checks++;
        if (cnt_a != HOLD_A || cnt_b != HOLD_B) begin
            n_fail++; $display("FAIL mid_rerun_ticks got %0d/%0d want %0d/%0d", cnt_a, cnt_b, HOLD_A, HOLD_B);
        end
    endtask

    task automatic test_arm_busy();
        set_inputs({16'h0100, 16'h4444}, 2'b11, 2'b10);
        want_ld = 2'b11; want_pc_a = 16'h0100; want_pc_b = 16'h0101; want_sp = 16'h4444;
        step(1'b1, 1'b1, 1'b0, 16'h0);
        run_to_done(100);          // arm held on every busy Clk
        n_checks++;
        if (cnt_a != HOLD_A || cnt_b != HOLD_B) begin
            n_fail++; $display("FAIL arm_busy_ticks got %0d/%0d want %0d/%0d", cnt_a, cnt_b, HOLD_A, HOLD_B);
        end
        repeat (5) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 16'($urandom));
        n_checks++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL done_sticky got %b want 1", bus.done); end
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NUM_REGS; i++) v[16*i +: 16] = 16'($urandom);
            if (k == 0) v[16 +: 16] = 16'hFFFF;
            set_inputs(v, NUM_REGS'($urandom), NUM_REGS'($urandom));
            want_ld = '0; want_pc_a = 16'h0; want_pc_b = 16'h0; want_sp = 16'h0;
            step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
            run_to_done(30);
            n_checks++;
            if (ld_ce != ((m_mask != '0) ? HOLD_A + HOLD_B : 0)) begin
                n_fail++; $display("FAIL random_strobe_ticks got %0d mask %b", ld_ce, m_mask);
            end
            repeat ($urandom_range(3, 12))
                step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
        end
    endtask

`ifdef CPU_INJ_TRACE_EN
    task automatic test_trace();
        set_inputs({16'h0010, 16'h0020}, 2'b11, 2'b00);
        want_ld = 2'b11; want_pc_a = 16'h0; want_pc_b = 16'h0; want_sp = 16'h0;
        step(1'b0, 1'b1, 1'b0, 16'h0);
        run_to_done(0);
        exp_q.delete();
        for (int i = 0; i < TRACE_DEPTH + 1; i++) begin
            if (i < TRACE_DEPTH) exp_q.push_back(16'(i));
            step(1'b1, 1'b0, 1'b0, 16'(i));
        end
        n_checks++;
        if (bus.trace_ovf !== 1'b1) begin n_fail++; $display("FAIL trace_ovf_set got %b want 1", bus.trace_ovf); end
        for (int i = 0; i < TRACE_DEPTH; i++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.trace_data !== e) begin n_fail++; $display("FAIL trace_pop%0d got %h want %h", i, bus.trace_data, e); end
            step(1'b0, 1'b0, 1'b1, 16'h0);
        end
        n_checks++;
        if (bus.trace_empty !== 1'b1) begin n_fail++; $display("FAIL trace_empty_end got %b want 1", bus.trace_empty); end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        bus.cpu_ce = 1'b0; bus.arm = 1'b0; bus.trace_rd = 1'b0; bus.trace_pc = 16'h0;
        set_inputs('0, '0, '0);
        test_reset();
        test_auto_arm();
        test_mask();
        test_wrap();
        test_reset_mid();
        test_arm_busy();
        test_random();
`ifdef CPU_INJ_TRACE_EN
        test_trace();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
